// File: rtl/cipher_display_pager_pkg.sv
// Shared widths and pager state encoding for the CRAFT result display path.
package craft_pkg;

    localparam int CRAFT_BLOCK_W = 64;
    localparam int DISP_DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_HI = 2'd1,
        SHOW_LO = 2'd2
    } pager_state_t;

endpackage

// File: rtl/cipher_display_pager_dwell_timer.sv
// Dwell counter: counts 0..PAGE_CYCLES-1 while run is high and pulses tick on
// the terminal count. clear has priority and restarts the count at zero.
module dwell_timer #(
    parameter int PAGE_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(PAGE_CYCLES - 1);

    generate
        if (PAGE_CYCLES < 2) begin : g_bad_dwell
            $error("dwell_timer: PAGE_CYCLES must be >= 2");
        end
    endgenerate

    logic [CW-1:0] count_q, count_d;
    logic          at_tc;

    assign at_tc = (count_q == TC);
    assign tick  = run & ~clear & at_tc;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = at_tc ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cipher_display_pager.sv
// Captures a 64-bit CRAFT result and pages its high/low halves onto the
// seven-segment driver, accepting a new result only after both halves were shown.
module cipher_display_pager
    import craft_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int PAGE_MS       = 1000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic [CRAFT_BLOCK_W-1:0] in_data,
    output logic                     in_ready,
    input  logic                     hold,
    output logic [DISP_DATA_W-1:0]   data,
    output logic                     en,
    output logic                     page,
    output logic                     shown_all
);

    localparam int PAGE_CYCLES = CLK_FREQUENCY / 1000 * PAGE_MS;

    // state   | meaning
    // IDLE    | nothing captured, display disabled
    // SHOW_HI | word[63:32] on the driver, page=0
    // SHOW_LO | word[31:0] on the driver, page=1

    pager_state_t             state_q, state_d;
    logic [CRAFT_BLOCK_W-1:0] word_q, word_d;
    logic [DISP_DATA_W-1:0]   data_q, data_d;
    logic                     page_q, page_d;
    logic                     shown_q, shown_d;
    logic                     ready_q, ready_d;
    logic                     en_q, en_d;
    logic                     capture, run, tick;

    assign capture = in_valid & ready_q;
    assign run     = (state_q != IDLE) & ~hold;

    dwell_timer #(.PAGE_CYCLES(PAGE_CYCLES)) u_dwell (
        .clk   (clk),
        .rstn  (rstn),
        .run   (run),
        .clear (capture),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        data_d  = data_q;
        page_d  = page_q;
        shown_d = shown_q;
        // A capture on the same edge as a dwell terminal restarts on the new word.
        if (capture) begin
            word_d  = in_data;
            state_d = SHOW_HI;
            data_d  = in_data[CRAFT_BLOCK_W-1:DISP_DATA_W];
            page_d  = 1'b0;
            shown_d = 1'b0;
        end else if (tick) begin
            unique case (state_q)
                SHOW_HI: begin
                    state_d = SHOW_LO;
                    data_d  = word_q[DISP_DATA_W-1:0];
                    page_d  = 1'b1;
                end
                SHOW_LO: begin
                    state_d = SHOW_HI;
                    data_d  = word_q[CRAFT_BLOCK_W-1:DISP_DATA_W];
                    page_d  = 1'b0;
                    shown_d = 1'b1;
                end
                default: ;
            endcase
        end
        ready_d = (state_d == IDLE) ? 1'b1 : shown_d;
        en_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            word_q  <= '0;
            data_q  <= '0;
            page_q  <= 1'b0;
            shown_q <= 1'b0;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            data_q  <= data_d;
            page_q  <= page_d;
            shown_q <= shown_d;
            ready_q <= ready_d;
            en_q    <= en_d;
        end
    end

    assign in_ready  = ready_q;
    assign data      = data_q;
    assign page      = page_q;
    assign shown_all = shown_q;
    assign en        = en_q;

endmodule
